ps2_lane_decoder: RTL and testbench
===================================

Name: ps2_lane_decoder

Overview:
- Sits directly downstream of PS2_Controller and consumes its received_data / received_data_en byte stream.
- Converts PS/2 set-2 scancodes (make, F0 break, E0 extended) into four registered lane key signals and a start pulse for the piano-tiles game FSM.
- Suppresses typematic repeats and recovers from truncated prefix sequences using a timeout.

Parameters:
- LANE0_CODE, 8'h23, make code for lane 0 (D)
- LANE1_CODE, 8'h2B, make code for lane 1 (F)
- LANE2_CODE, 8'h3B, make code for lane 2 (J)
- LANE3_CODE, 8'h42, make code for lane 3 (K)
- START_CODE, 8'h29, make code for start (Space)
- TIMEOUT_CYCLES, 100000, max cycles allowed between a prefix byte and its following byte (2 ms at 50 MHz)
- TO_W, 17, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- received_data  in  8  byte from PS2_Controller; valid only when received_data_en=1
- received_data_en  in  1  one-cycle strobe, new byte present
- lane_held  out  4  level; bit i=1 while lane i key is down
- lane_press  out  4  one-cycle pulse on bit i when lane i goes up->down
- start_press  out  1  one-cycle pulse when START_CODE goes up->down
- prefix_timeout  out  1  one-cycle pulse when a pending prefix is dropped

Behaviour:
- Reset (synchronous, dominates every other input in the same cycle): state=IDLE, counter=0, lane_held=0, start_held=0, lane_press=0, start_press=0, prefix_timeout=0.
- FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen). Transitions occur only on cycles with received_data_en=1, except timeout.
- IDLE:
  - byte F0 -> BRK.
  - byte E0 -> EXT.
  - byte equal to a lane or start code -> make event, stay in IDLE.
  - any other byte -> ignored, stay in IDLE.
- BRK:
  - byte equal to a lane or start code -> break event, then IDLE.
  - any other byte -> IDLE with no effect. This includes F0 and E0; they are not re-treated as prefixes.
- EXT:
  - byte F0 -> EXT_BRK.
  - any other byte -> IDLE. Extended keys are never mapped, even if the low byte matches a lane code.
- EXT_BRK: any byte -> IDLE with no effect.
- Make event, lane i:
  - If lane_held[i]=0: lane_held[i]<=1 and lane_press[i]<=1 for exactly one cycle.
  - If lane_held[i]=1 (typematic repeat): no change, no pulse.
- Break event, lane i: lane_held[i]<=0 with no pulse. A break for a key that is not held has no effect.
- Start key: tracked the same way with an internal start_held; start_press pulses only on the up->down edge.
- Latency: all outputs are registered. lane_press / start_press / lane_held change on the clock edge that samples received_data_en=1, so they are visible in the cycle after the strobe cycle.
- Pulses deassert on the next edge unless a new qualifying event occurs. A pulse is at most one cycle wide per byte.
- Timeout:
  - The counter clears on entry to any non-IDLE state and on every accepted byte.
  - It increments each cycle while in a non-IDLE state with no strobe.
  - When the counter reaches TIMEOUT_CYCLES-1 and no strobe is present: state<=IDLE, counter<=0, prefix_timeout pulses for one cycle.
  - If a strobe arrives in that same cycle, the byte is processed normally in the current state and no timeout fires.
- In IDLE the counter holds at 0.
- Multiple lanes may be held simultaneously. Each lane is independent, and only one lane can change per byte.
- Reset mid-sequence (for example after F0): the pending prefix is discarded and all held bits clear. The following byte is interpreted from IDLE.
- Codes outside the parameter set never affect any output.

Test Plan:
- Reset then bytes 23, F0, 23 -> lane_press=4'b0001 for 1 cycle after first strobe, lane_held[0]=1 until cycle after third strobe, then 0; no second press pulse.
- Bytes 2B, 2B, 2B (typematic) -> exactly one lane_press[1] pulse; lane_held[1] stays 1.
- Bytes 3B, 42 then F0 3B -> lane_held goes 4'b0100, 4'b1100, 4'b1000; presses on bits 2 then 3 only.
- Bytes E0, 23 then E0, F0, 23 -> no lane_press, lane_held stays 4'b0000, FSM back in IDLE; next 23 produces lane_press[0].
- Byte F0 then no strobe for TIMEOUT_CYCLES cycles -> prefix_timeout pulses once; following byte 29 gives start_press=1 (treated as make, not break).
- lane_held=4'b1111, reset asserted for 1 cycle mid F0 sequence -> all outputs 0 next cycle; next byte 42 is a make, so lane_press=4'b1000.

Source files
------------

// File: rtl/ps2_lane_decoder.sv
// PS/2 set-2 scancode decoder: four lane key levels/press pulses plus a start pulse, with prefix timeout.
// Latency: one cycle from the received_data_en strobe to registered outputs.
// Backpressure: none; every strobed byte is consumed in the cycle it arrives.
module ps2_lane_decoder #(
   parameter logic [7:0] LANE0_CODE     = 8'h23,
   parameter logic [7:0] LANE1_CODE     = 8'h2B,
   parameter logic [7:0] LANE2_CODE     = 8'h3B,
   parameter logic [7:0] LANE3_CODE     = 8'h42,
   parameter logic [7:0] START_CODE     = 8'h29,
   parameter int         TIMEOUT_CYCLES = 100000,
   parameter int         TO_W           = 17
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] received_data,
   input  logic       received_data_en,
   output logic [3:0] lane_held,
   output logic [3:0] lane_press,
   output logic       start_press,
   output logic       prefix_timeout
);

   localparam logic [7:0]      BRK_CODE = 8'hF0;
   localparam logic [7:0]      EXT_CODE = 8'hE0;
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BRK     = 2'd1,
      EXT     = 2'd2,
      EXT_BRK = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            start_held_q, start_held_d;
   logic [3:0]      lane_held_d;
   logic [3:0]      lane_press_d;
   logic            start_press_d;
   logic            timeout_d;
   logic [3:0]      lane_hit;
   logic            start_hit;

   always_comb begin
      lane_hit[0] = (received_data == LANE0_CODE);
      lane_hit[1] = (received_data == LANE1_CODE);
      lane_hit[2] = (received_data == LANE2_CODE);
      lane_hit[3] = (received_data == LANE3_CODE);
      start_hit   = (received_data == START_CODE);
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      lane_held_d   = lane_held;
      start_held_d  = start_held_q;
      lane_press_d  = 4'b0000;
      start_press_d = 1'b0;
      timeout_d     = 1'b0;

      if (received_data_en) begin
         // Any accepted byte restarts the prefix timer, whatever state it leads to.
         cnt_d = '0;
         case (state_q)
            IDLE: begin
               if (received_data == BRK_CODE) begin
                  state_d = BRK;
               end else if (received_data == EXT_CODE) begin
                  state_d = EXT;
               end else begin
                  // Make: only the up->down edge produces a pulse, so typematic repeats are silent.
                  for (int i = 0; i < 4; i++) begin
                     if (lane_hit[i] && !lane_held[i]) begin
                        lane_held_d[i]  = 1'b1;
                        lane_press_d[i] = 1'b1;
                     end
                  end
                  if (start_hit && !start_held_q) begin
                     start_held_d  = 1'b1;
                     start_press_d = 1'b1;
                  end
               end
            end
            BRK: begin
               state_d = IDLE;
               for (int i = 0; i < 4; i++) begin
                  if (lane_hit[i]) lane_held_d[i] = 1'b0;
               end
               if (start_hit) start_held_d = 1'b0;
            end
            EXT: begin
               // Extended keys are never mapped, even when the low byte collides with a lane code.
               state_d = (received_data == BRK_CODE) ? EXT_BRK : IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else if (state_q != IDLE) begin
         if (cnt_q == TO_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            timeout_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         lane_held      <= 4'b0000;
         start_held_q   <= 1'b0;
         lane_press     <= 4'b0000;
         start_press    <= 1'b0;
         prefix_timeout <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         lane_held      <= lane_held_d;
         start_held_q   <= start_held_d;
         lane_press     <= lane_press_d;
         start_press    <= start_press_d;
         prefix_timeout <= timeout_d;
      end
   end

endmodule

// File: tb/tb_ps2_lane_decoder.sv
// Bench for ps2_lane_decoder: directed scenarios followed by random byte traffic against a key-state model.
module tb_ps2_lane_decoder;

   localparam int T = 16;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] received_data = 8'h00;
   logic       received_data_en = 1'b0;
   logic [3:0] lane_held;
   logic [3:0] lane_press;
   logic       start_press;
   logic       prefix_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   ps2_lane_decoder #(
      .TIMEOUT_CYCLES(T),
      .TO_W(5)
   ) dut (
      .CLOCK_50        (CLOCK_50),
      .reset           (reset),
      .received_data   (received_data),
      .received_data_en(received_data_en),
      .lane_held       (lane_held),
      .lane_press      (lane_press),
      .start_press     (start_press),
      .prefix_timeout  (prefix_timeout)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Model: which of the five keys are down, plus the prefix bytes still awaiting a follow-up.
   logic [7:0] key_codes [5] = '{8'h23, 8'h2B, 8'h3B, 8'h42, 8'h29};
   logic [4:0] down = '0;
   logic [7:0] pend [$];
   int         silent = 0;
   logic [3:0] exp_press;
   logic       exp_start;
   logic       exp_to;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic key_event(input logic [7:0] b, input bit make);
      for (int k = 0; k < 5; k++) begin
         if (b == key_codes[k]) begin
            if (make && !down[k]) begin
               down[k] = 1'b1;
               if (k < 4) exp_press[k] = 1'b1;
               else       exp_start    = 1'b1;
            end else if (!make) begin
               down[k] = 1'b0;
            end
         end
      end
   endtask

   task automatic model_cycle(input bit rst, input bit en, input logic [7:0] b);
      exp_press = 4'b0000;
      exp_start = 1'b0;
      exp_to    = 1'b0;
      if (rst) begin
         down = '0;
         pend.delete();
         silent = 0;
      end else if (en) begin
         silent = 0;
         if (pend.size() == 0) begin
            if (b == 8'hF0 || b == 8'hE0) pend.push_back(b);
            else key_event(b, 1'b1);
         end else if (pend.size() == 1 && pend[0] == 8'hF0) begin
            key_event(b, 1'b0);
            pend.delete();
         end else if (pend.size() == 1 && pend[0] == 8'hE0 && b == 8'hF0) begin
            pend.push_back(b);
         end else begin
            pend.delete();
         end
      end else if (pend.size() != 0) begin
         silent++;
         if (silent == T) begin
            pend.delete();
            silent = 0;
            exp_to = 1'b1;
         end
      end
   endtask

   task automatic step(input bit rst, input bit en, input logic [7:0] b);
      @(negedge CLOCK_50);
      reset            = rst;
      received_data_en = en;
      received_data    = b;
      model_cycle(rst, en, b);
      @(posedge CLOCK_50);
      #1;
      check_eq("lane_held", {28'd0, lane_held}, {28'd0, down[3:0]});
      check_eq("lane_press", {28'd0, lane_press}, {28'd0, exp_press});
      check_eq("start_press", {31'd0, start_press}, {31'd0, exp_start});
      check_eq("prefix_timeout", {31'd0, prefix_timeout}, {31'd0, exp_to});
   endtask

   task automatic send(input logic [7:0] b);
      step(1'b0, 1'b1, b);
      step(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      int n_to;
      int r;
      logic [7:0] b;

      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h23);
      check_eq("reset_held", {28'd0, lane_held}, 32'd0);

      // Make, break, no second press.
      step(1'b0, 1'b1, 8'h23);
      check_eq("tp1_press", {28'd0, lane_press}, 32'h1);
      step(1'b0, 1'b0, 8'h00);
      send(8'hF0);
      step(1'b0, 1'b1, 8'h23);
      check_eq("tp1_release", {28'd0, lane_held}, 32'h0);
      check_eq("tp1_nopress", {28'd0, lane_press}, 32'h0);

      // Typematic repeats.
      send(8'h2B);
      send(8'h2B);
      step(1'b0, 1'b1, 8'h2B);
      check_eq("tp2_repeat", {28'd0, lane_press}, 32'h0);
      check_eq("tp2_held", {28'd0, lane_held}, 32'h2);
      send(8'hF0);
      send(8'h2B);

      // Two lanes overlapping.
      send(8'h3B);
      send(8'h42);
      check_eq("tp3_both", {28'd0, lane_held}, 32'hC);
      send(8'hF0);
      send(8'h3B);
      check_eq("tp3_left", {28'd0, lane_held}, 32'h8);
      send(8'hF0);
      send(8'h42);

      // Extended keys ignored.
      send(8'hE0);
      send(8'h23);
      send(8'hE0);
      send(8'hF0);
      send(8'h23);
      check_eq("tp4_ext", {28'd0, lane_held}, 32'h0);
      step(1'b0, 1'b1, 8'h23);
      check_eq("tp4_after", {28'd0, lane_press}, 32'h1);
      send(8'hF0);
      send(8'h23);

      // Timeout on a dangling break prefix.
      step(1'b0, 1'b1, 8'hF0);
      n_to = 0;
      for (int i = 0; i < T + 3; i++) begin
         step(1'b0, 1'b0, 8'h00);
         if (prefix_timeout) n_to++;
      end
      check_eq("tp5_to_count", n_to, 1);
      step(1'b0, 1'b1, 8'h29);
      check_eq("tp5_start", {31'd0, start_press}, 32'h1);
      send(8'hF0);
      send(8'h29);

      // Reset in the middle of a break sequence.
      send(8'h23);
      send(8'h2B);
      send(8'h3B);
      send(8'h42);
      send(8'hF0);
      step(1'b1, 1'b0, 8'h00);
      check_eq("tp6_held", {28'd0, lane_held}, 32'h0);
      step(1'b0, 1'b1, 8'h42);
      check_eq("tp6_make", {28'd0, lane_press}, 32'h8);

      // Random traffic, including long silent stretches to hit the timeout.
      for (int c = 0; c < 4000; c++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3, 4: b = key_codes[r];
            5:             b = 8'hF0;
            6:             b = 8'hE0;
            default:       b = 8'($urandom);
         endcase
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0), b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
